reg_file_sb: RTL and testbench

Parametrised successor to the current 32x32 RegisterFile. It provides one synchronous write port and two asynchronous read ports, with x0 hardwired to zero. It adds a per-register busy scoreboard so the datapath can detect reads of registers whose producer has issued but not yet written back. It sits between decode (rs1/rs2/rd) and writeback in the datapath.

---
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with one synchronous write port,
// two combinational read ports, x0 hardwired to zero and a per-register
// busy scoreboard for in-flight producers.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data
// (and the resulting busy state) to matching read ports.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]   write_data,
    input  logic              reg_write,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              any_busy
);

    localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic w_rs1_ok;
    logic w_rs2_ok;
    logic w_wr_en;
    logic w_set_en;

    // Index 0 is excluded so x0 can never be written or marked busy.
    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < LP_NREGS);
    endfunction

    assign w_rs1_ok = f_in_range(rs1);
    assign w_rs2_ok = f_in_range(rs2);
    assign w_wr_en  = reg_write & f_in_range(rd);
    assign w_set_en = busy_set & f_in_range(busy_rd);

    // Register storage: clears asynchronously, writes on rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= write_data;
        end
    end

    // Scoreboard: a new producer (set) takes priority over a writeback (clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_set_en && (busy_rd == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_en && (rd == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read port 1: stored value, zero for x0 or out-of-range addresses.
    always_comb begin
        read_data1 = '0;
        rs1_busy   = 1'b0;
        if (w_rs1_ok) begin
            read_data1 = r_regs[rs1];
            rs1_busy   = r_busy[rs1];
        end
`ifdef REGFILE_BYPASS_EN
        // Reset gating keeps outputs at zero even if a write is presented.
        if (rst_n && w_wr_en && (rs1 == rd)) begin
            read_data1 = write_data;
            rs1_busy   = busy_set && (busy_rd == rd);
        end
`endif
    end

    // Read port 2: same behaviour as port 1, independent address.
    always_comb begin
        read_data2 = '0;
        rs2_busy   = 1'b0;
        if (w_rs2_ok) begin
            read_data2 = r_regs[rs2];
            rs2_busy   = r_busy[rs2];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && w_wr_en && (rs2 == rd)) begin
            read_data2 = write_data;
            rs2_busy   = busy_set && (busy_rd == rd);
        end
`endif
    end

    // Bit 0 is never set, so a plain reduction covers registers 1..NREGS-1.
    assign any_busy = |r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: vector table plus hand-written sequences
// for same-cycle write/read, out-of-range addressing and async reset.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd, busy_rd;
    logic [31:0] write_data;
    logic        reg_write, busy_set;
    logic [31:0] read_data1, read_data2;
    logic        rs1_busy, rs2_busy, any_busy;
    logic [31:0] s_rd1, s_rd2;
    logic        s_b1, s_b2, s_any;

    int n_vec;
    int n_err;

    reg_file_sb #(.XLEN(32), .NREGS(32), .ADDR_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .read_data1(read_data1), .read_data2(read_data2),
        .rd(rd), .write_data(write_data), .reg_write(reg_write),
        .busy_set(busy_set), .busy_rd(busy_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .any_busy(any_busy)
    );

    // Smaller instance so addresses 20..31 are out of range.
    reg_file_sb #(.XLEN(32), .NREGS(20), .ADDR_W(5)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .read_data1(s_rd1), .read_data2(s_rd2),
        .rd(rd), .write_data(write_data), .reg_write(reg_write),
        .busy_set(busy_set), .busy_rd(busy_rd),
        .rs1_busy(s_b1), .rs2_busy(s_b2), .any_busy(s_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] wdata;
        logic        we, bset;
        logic [4:0]  brd;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2, e_any;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0; write_data = '0;
        reg_write = 1'b0; busy_set = 1'b0; busy_rd = '0;
    endtask

    logic [31:0] exp_byp;

    initial begin
        n_vec = 0;
        n_err = 0;
        // rs1 rs2 rd wdata we bset brd | rd1 rd2 b1 b2 any (pre-edge outputs)
        vt[0]  = '{5'd1,  5'd31, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b0, 1'b0};
        vt[1]  = '{5'd4,  5'd0,  5'd3,  32'hABCD1234, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b0, 1'b0};
        vt[2]  = '{5'd3,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'hABCD1234, 32'h0,    1'b0, 1'b0, 1'b0};
        vt[3]  = '{5'd0,  5'd3,  5'd0,  32'hFFFFFFFF, 1'b1, 1'b1, 5'd0,  32'h0,        32'hABCD1234, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b0, 1'b0};
        vt[5]  = '{5'd3,  5'd5,  5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  32'hABCD1234, 32'h0,    1'b0, 1'b0, 1'b0};
        vt[6]  = '{5'd5,  5'd5,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b1, 1'b1};
        vt[7]  = '{5'd3,  5'd6,  5'd5,  32'h42,       1'b1, 1'b0, 5'd0,  32'hABCD1234, 32'h0,    1'b0, 1'b0, 1'b1};
        vt[8]  = '{5'd3,  5'd5,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'hABCD1234, 32'h42,   1'b0, 1'b0, 1'b0};
        vt[9]  = '{5'd3,  5'd8,  5'd7,  32'h11,       1'b1, 1'b1, 5'd7,  32'hABCD1234, 32'h0,    1'b0, 1'b0, 1'b0};
        vt[10] = '{5'd7,  5'd7,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h11,       32'h11,   1'b1, 1'b1, 1'b1};
        vt[11] = '{5'd2,  5'd0,  5'd7,  32'h22,       1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b0, 1'b1};
        vt[12] = '{5'd7,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h22,       32'h0,    1'b0, 1'b0, 1'b0};
        vt[13] = '{5'd0,  5'd0,  5'd10, 32'h1234,     1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b0, 1'b0};
        vt[14] = '{5'd10, 5'd10, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h1234,     32'h1234, 1'b0, 1'b0, 1'b0};
        vt[15] = '{5'd31, 5'd0,  5'd0,  32'h0,        1'b0, 1'b1, 5'd31, 32'h0,        32'h0,    1'b0, 1'b0, 1'b0};
        vt[16] = '{5'd31, 5'd31, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b1, 1'b1};
        vt[17] = '{5'd3,  5'd10, 5'd31, 32'hDEAD,     1'b1, 1'b0, 5'd0,  32'hABCD1234, 32'h1234, 1'b0, 1'b0, 1'b1};
        vt[18] = '{5'd31, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'hDEAD,     32'h0,    1'b0, 1'b0, 1'b0};

        // Power-on reset with a write presented: outputs must stay zero.
        rst_n = 1'b0;
        idle();
        rs1 = 5'd3; rd = 5'd3; write_data = 32'h77; reg_write = 1'b1;
        #12;
        chk("por rd1", read_data1, 32'h0);
        chk("por any", {31'h0, any_busy}, 32'h0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: inputs driven just after an edge, outputs sampled at negedge.
        for (int i = 0; i < 19; i++) begin
            rs1 = vt[i].rs1; rs2 = vt[i].rs2; rd = vt[i].rd;
            write_data = vt[i].wdata; reg_write = vt[i].we;
            busy_set = vt[i].bset; busy_rd = vt[i].brd;
            @(negedge clk);
            chk($sformatf("v%0d rd1", i), read_data1, vt[i].e_rd1);
            chk($sformatf("v%0d rd2", i), read_data2, vt[i].e_rd2);
            chk($sformatf("v%0d b1", i),  {31'h0, rs1_busy}, {31'h0, vt[i].e_b1});
            chk($sformatf("v%0d b2", i),  {31'h0, rs2_busy}, {31'h0, vt[i].e_b2});
            chk($sformatf("v%0d any", i), {31'h0, any_busy}, {31'h0, vt[i].e_any});
            @(posedge clk); #1;
        end

        // Same-cycle read of the register being written.
        idle();
        rs1 = 5'd9; rd = 5'd9; write_data = 32'h5A5A5A5A; reg_write = 1'b1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h5A5A5A5A;
`else
        exp_byp = 32'h0;
`endif
        @(negedge clk);
        chk("samecyc rd1", read_data1, exp_byp);
        @(posedge clk); #1;
        reg_write = 1'b0;
        @(negedge clk);
        chk("nextcyc rd1", read_data1, 32'h5A5A5A5A);
        @(posedge clk); #1;

        // Out-of-range addresses on the 20-register instance.
        idle();
        rd = 5'd25; write_data = 32'h77; reg_write = 1'b1;
        busy_set = 1'b1; busy_rd = 5'd25;
        @(posedge clk); #1;
        idle();
        rs1 = 5'd25;
        @(negedge clk);
        chk("oor small rd1", s_rd1, 32'h0);
        chk("oor small b1", {31'h0, s_b1}, 32'h0);
        chk("oor small any", {31'h0, s_any}, 32'h0);
        chk("inr big rd1", read_data1, 32'h77);
        chk("inr big b1", {31'h0, rs1_busy}, 32'h1);
        @(posedge clk); #1;
        rd = 5'd19; write_data = 32'h99; reg_write = 1'b1;
        @(posedge clk); #1;
        idle();
        rs2 = 5'd19;
        @(negedge clk);
        chk("top small rd2", s_rd2, 32'h99);
        @(posedge clk); #1;

        // Async reset mid-operation with regs[3] written and busy[3] set.
        idle();
        rs1 = 5'd3; busy_set = 1'b1; busy_rd = 5'd3;
        @(posedge clk); #1;
        busy_set = 1'b0;
        chk("pre-rst rd1", read_data1, 32'hABCD1234);
        chk("pre-rst b1", {31'h0, rs1_busy}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst rd1", read_data1, 32'h0);
        chk("rst b1", {31'h0, rs1_busy}, 32'h0);
        chk("rst any", {31'h0, any_busy}, 32'h0);
        rd = 5'd3; write_data = 32'h55; reg_write = 1'b1;
        busy_set = 1'b1; busy_rd = 5'd3;
        @(posedge clk); #1;
        chk("in-rst rd1", read_data1, 32'h0);
        chk("in-rst b1", {31'h0, rs1_busy}, 32'h0);
        @(negedge clk);
        idle();
        rs1 = 5'd3; rs2 = 5'd19;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst rd1", read_data1, 32'h0);
        chk("post-rst rd2", read_data2, 32'h0);
        chk("post-rst any", {31'h0, any_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
